// File: rtl/simd_lane_accum_stream_pkg.sv
// Shared types for the SIMD lane accumulator stream: lane geometry, FSM states,
// and packed-lane slice arithmetic.
package simd_stream_pkg;

  localparam int LANES = 4;
  localparam int IN_W  = 11;
  localparam int ACC_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    EMIT  = 2'd2
  } state_e;

  function automatic int lane_off(input int k, input int w);
    return k * w;
  endfunction

endpackage

// File: rtl/simd_lane_accum_stream_if.sv
// Control, upstream-pop and downstream-push signals of the lane accumulator,
// grouped so the block and its environment connect through one bundle.
interface simd_lane_accum_stream_if #(
  parameter int LANES = 4,
  parameter int IN_W  = 11,
  parameter int ACC_W = 16
);
  logic                     ap_start;
  logic                     ap_ready;
  logic                     ap_done;
  logic                     ap_idle;
  logic [LANES*IN_W-1:0]    in_data;
  logic                     in_empty_n;
  logic                     in_read;
  logic [LANES*ACC_W-1:0]   out_data;
  logic                     out_full_n;
  logic                     out_write;
  logic [LANES-1:0]         out_ovf;

  modport slave (
    input  ap_start, in_data, in_empty_n, out_full_n,
    output ap_ready, ap_done, ap_idle, in_read, out_data, out_write, out_ovf
  );

  modport master (
    output ap_start, in_data, in_empty_n, out_full_n,
    input  ap_ready, ap_done, ap_idle, in_read, out_data, out_write, out_ovf
  );
endinterface

// File: rtl/simd_lane_accum_stream_acc.sv
// One lane accumulator with sticky carry-out flag. Build option
// SIMD_LANE_ACC_SATURATE_EN clamps at full scale instead of wrapping.
module simd_lane_acc #(
  parameter int IN_W  = 11,
  parameter int ACC_W = 16
) (
  input  logic             ap_clk,
  input  logic             ap_rst_n,
  input  logic             clr_i,
  input  logic             add_i,
  input  logic [IN_W-1:0]  din_i,
  output logic [ACC_W-1:0] acc_nxt_o,
  output logic             ovf_nxt_o
);

  logic [ACC_W-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic [ACC_W:0]   sum;

  // MSB of the result is the carry out of the lane, independent of clamping
  function automatic logic [ACC_W:0] lane_add(input logic [ACC_W-1:0] a,
                                              input logic [IN_W-1:0]  b);
    logic [ACC_W:0] s;
    s = {1'b0, a} + (ACC_W+1)'(b);
`ifdef SIMD_LANE_ACC_SATURATE_EN
    if (s[ACC_W]) s[ACC_W-1:0] = '1;
`endif
    return s;
  endfunction

  always_comb begin
    sum       = lane_add(acc_q, din_i);
    acc_nxt_o = sum[ACC_W-1:0];
    ovf_nxt_o = ovf_q | sum[ACC_W];
    acc_d     = acc_q;
    ovf_d     = ovf_q;
    if (clr_i) begin
      acc_d = '0;
      ovf_d = 1'b0;
    end else if (add_i) begin
      acc_d = acc_nxt_o;
      ovf_d = ovf_nxt_o;
    end
  end

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      acc_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      ovf_q <= ovf_d;
    end
  end

endmodule

// File: rtl/simd_lane_accum_stream.sv
// Per-lane frame accumulator between the SIMD adder and the HLS output FIFO.
// Optional build macro: SIMD_LANE_ACC_SATURATE_EN (clamp instead of wrap).
module simd_lane_accum_stream #(
  parameter int LANES     = simd_stream_pkg::LANES,
  parameter int IN_W      = simd_stream_pkg::IN_W,
  parameter int ACC_W     = simd_stream_pkg::ACC_W,
  parameter int FRAME_LEN = 8
) (
  input logic                   ap_clk,
  input logic                   ap_rst_n,
  simd_lane_accum_stream_if.slave bus
);
  import simd_stream_pkg::*;

  localparam int CNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_LEN - 1);

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   clr, add, capture;
  logic                   in_read, out_write, ap_ready;
  logic [ACC_W-1:0]       acc_nxt [LANES];
  logic [LANES-1:0]       ovf_nxt;
  logic [LANES*ACC_W-1:0] out_data_q, out_data_d;
  logic [LANES-1:0]       out_ovf_q, out_ovf_d;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    simd_lane_acc #(
      .IN_W  (IN_W),
      .ACC_W (ACC_W)
    ) u_lane (
      .ap_clk    (ap_clk),
      .ap_rst_n  (ap_rst_n),
      .clr_i     (clr),
      .add_i     (add),
      .din_i     (bus.in_data[lane_off(k, IN_W) +: IN_W]),
      .acc_nxt_o (acc_nxt[k]),
      .ovf_nxt_o (ovf_nxt[k])
    );
  end

  // Strobes are held low while reset is asserted, whatever the state register holds
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    in_read   = 1'b0;
    out_write = 1'b0;
    ap_ready  = 1'b0;
    clr       = 1'b0;
    add       = 1'b0;
    capture   = 1'b0;
    if (ap_rst_n) begin
      case (state_q)
        IDLE: begin
          if (bus.ap_start) begin
            ap_ready = 1'b1;
            clr      = 1'b1;
            cnt_d    = '0;
            state_d  = ACCUM;
          end
        end
        ACCUM: begin
          in_read = bus.in_empty_n;
          if (bus.in_empty_n) begin
            add = 1'b1;
            if (cnt_q == CNT_LAST) begin
              capture = 1'b1;
              cnt_d   = '0;
              state_d = EMIT;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        EMIT: begin
          out_write = bus.out_full_n;
          if (bus.out_full_n) begin
            clr   = 1'b1;
            cnt_d = '0;
            if (bus.ap_start) begin
              ap_ready = 1'b1;
              state_d  = ACCUM;
            end else begin
              state_d = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Result word includes the final input of the frame, taken from the lane adders
  always_comb begin
    out_data_d = out_data_q;
    out_ovf_d  = out_ovf_q;
    if (capture) begin
      for (int k = 0; k < LANES; k++) begin
        out_data_d[lane_off(k, ACC_W) +: ACC_W] = acc_nxt[k];
      end
      out_ovf_d = ovf_nxt;
    end
  end

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      out_data_q <= '0;
      out_ovf_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      out_data_q <= out_data_d;
      out_ovf_q  <= out_ovf_d;
    end
  end

  assign bus.in_read   = in_read;
  assign bus.out_write = out_write;
  assign bus.ap_done   = out_write;
  assign bus.ap_ready  = ap_ready;
  assign bus.ap_idle   = (state_q == IDLE);
  assign bus.out_data  = out_data_q;
  assign bus.out_ovf   = out_ovf_q;

endmodule
